// File: rtl/sramlike_responder.sv
// SRAM-like slave responder: byte-strobed word memory with an in-order response FIFO
// that returns each accepted request no earlier than LATENCY cycles after acceptance.
module sramlike_responder #(
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [2:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        stall,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(LATENCY + 1);

    localparam logic [CW-1:0] CountFull = CW'(DEPTH);
    localparam logic [AW-1:0] AgeMax    = AW'(LATENCY);
    localparam logic [AW-1:0] AgeFire   = AW'(LATENCY - 1);

    logic [31:0]          mem_q [0:(1 << ADDR_BITS) - 1];
    logic [ADDR_BITS-1:0] index;
    logic [31:0]          wmerged;

    logic [DEPTH-1:0] is_wr_q;
    logic [31:0]      data_q [DEPTH];
    logic [AW-1:0]    age_q  [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             data_ok_q;
    logic [31:0]      rdata_q;

    logic accept;
    logic retire;
    logic unused_bits;

    assign unused_bits = ^{size, addr[31:ADDR_BITS+2], addr[1:0]};
    assign index       = addr[ADDR_BITS+1:2];

    // resetn gates acceptance directly so nothing is taken while reset is held.
    assign addr_ok = resetn && req && !stall && (count_q != CountFull);
    assign accept  = addr_ok;
    // Registering at the edge where age is LATENCY-1 puts data_ok LATENCY cycles after accept.
    assign retire  = (count_q != '0) && (age_q[rptr_q] >= AgeFire);

    assign data_ok = data_ok_q;
    assign rdata   = rdata_q;

    always_comb begin
        wmerged = mem_q[index];
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                wmerged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Backing array is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem_q[index] <= wmerged;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            is_wr_q   <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= 32'h0;
                age_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (age_q[i] != AgeMax) begin
                    age_q[i] <= age_q[i] + AW'(1);
                end
            end

            if (accept) begin
                is_wr_q[wptr_q] <= wr;
                data_q[wptr_q]  <= wr ? 32'h0 : mem_q[index];
                age_q[wptr_q]   <= '0;
                wptr_q          <= wptr_q + PW'(1);
            end

            data_ok_q <= retire;
            if (retire) begin
                rdata_q <= is_wr_q[rptr_q] ? 32'h0 : data_q[rptr_q];
                rptr_q  <= rptr_q + PW'(1);
            end

            unique case ({accept, retire})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_sramlike_responder.sv
// Directed bench: a default instance (LATENCY=2) and a deep-latency instance (LATENCY=5)
// used where the FIFO must fill or where a reset must land before any response.
module tb_sramlike_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_a, req_b, wr, stall;
    logic [2:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        ok_a, dok_a, ok_b, dok_b;
    logic [31:0] rd_a, rd_b;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    logic [31:0] resp_a[$];
    int          rcyc_a[$];
    logic [31:0] resp_b[$];

    sramlike_responder u_dut (
        .clk(clk), .resetn(resetn), .req(req_a), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .stall(stall), .addr_ok(ok_a), .data_ok(dok_a),
        .rdata(rd_a)
    );

    sramlike_responder #(.ADDR_BITS(12), .DEPTH(4), .LATENCY(5)) u_dut_deep (
        .clk(clk), .resetn(resetn), .req(req_b), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .stall(stall), .addr_ok(ok_b), .data_ok(dok_b),
        .rdata(rd_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dok_a) begin
            resp_a.push_back(rd_a);
            rcyc_a.push_back(cyc);
        end
        if (dok_b) resp_b.push_back(rd_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request and hold it until accepted; returns wait cycles and accept cycle.
    task automatic issue(input int sel, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output int waited, output int acc);
        wr = w; addr = a; wdata = d; wstrb = s;
        if (sel == 0) req_a = 1'b1; else req_b = 1'b1;
        waited = 0;
        #1;
        while (!((sel == 0) ? ok_a : ok_b) && waited < 100) begin
            @(negedge clk); #1;
            waited++;
        end
        if (waited >= 100) check("issue_timeout", 32'(waited), 32'd0);
        @(posedge clk); #1;
        acc = cyc;
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic wait_resp(input int sel, input int n);
        int sz;
        int t;
        t = 0;
        sz = (sel == 0) ? resp_a.size() : resp_b.size();
        while (sz < n && t < 100) begin
            @(negedge clk); #2;
            t++;
            sz = (sel == 0) ? resp_a.size() : resp_b.size();
        end
        if (sz < n) check("resp_timeout", 32'(sz), 32'(n));
        @(negedge clk);
    endtask

    int   w, acc0, acc1, base, n;
    logic sampled;
    logic okh [16];
    logic dokh[16];

    initial begin
        resetn = 1'b0; req_a = 1'b1; req_b = 1'b1; wr = 1'b0; stall = 1'b0;
        size = 3'd2; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
        #3;
        check("rst_addr_ok_a", 32'(ok_a), 32'd0);
        check("rst_addr_ok_b", 32'(ok_b), 32'd0);
        check("rst_data_ok", 32'(dok_a), 32'd0);
        check("rst_rdata", rd_a, 32'h0);
        @(negedge clk); req_a = 1'b0; req_b = 1'b0;
        @(negedge clk); resetn = 1'b1;

        // Write then read back, with exact latency.
        issue(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, w, acc0);
        check("first_accept_wait", 32'(w), 32'd0);
        issue(0, 1'b0, 32'h100, 32'h0, 4'h0, w, acc1);
        wait_resp(0, 2);
        check("wr_rdata", resp_a[0], 32'h0);
        check("wr_latency", 32'(rcyc_a[0] - acc0), 32'd2);
        check("rd_rdata", resp_a[1], 32'hDEADBEEF);
        check("rd_latency", 32'(rcyc_a[1] - acc1), 32'd2);
        #1;
        check("hold_data_ok", 32'(dok_a), 32'd0);
        check("hold_rdata", rd_a, 32'hDEADBEEF);

        // Byte strobes, zero strobe, low-bit and high-bit aliasing.
        issue(0, 1'b1, 32'h100, 32'h11223344, 4'hF, w, acc0);
        issue(0, 1'b1, 32'h100, 32'hAABBCCDD, 4'b0101, w, acc0);
        issue(0, 1'b0, 32'h100, 32'h0, 4'h0, w, acc0);
        issue(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0, w, acc0);
        issue(0, 1'b0, 32'h103, 32'h0, 4'h0, w, acc0);
        issue(0, 1'b0, 32'h4100, 32'h0, 4'h0, w, acc0);
        wait_resp(0, 8);
        check("strb_wr0", resp_a[2], 32'h0);
        check("strb_wr1", resp_a[3], 32'h0);
        check("strb_read", resp_a[4], 32'h11BB33DD);
        check("zero_strb_wr", resp_a[5], 32'h0);
        check("zero_strb_read", resp_a[6], 32'h11BB33DD);
        check("alias_read", resp_a[7], 32'h11BB33DD);

        // Stall blocks acceptance.
        stall = 1'b1; req_a = 1'b1; wr = 1'b0; addr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall_ok_%0d", i), 32'(ok_a), 32'd0);
            @(negedge clk);
        end
        stall = 1'b0;
        issue(0, 1'b0, 32'h100, 32'h0, 4'h0, w, acc0);
        check("stall_release_wait", 32'(w), 32'd0);
        wait_resp(0, 9);
        check("stall_rdata", resp_a[8], 32'h11BB33DD);
        check("stall_resp_count", 32'(resp_a.size()), 32'd9);

        // Deep instance: preload six words, then fill the FIFO.
        for (int i = 0; i < 6; i++) begin
            issue(1, 1'b1, 32'h200 + 32'(4 * i), 32'hB0000000 + 32'(i), 4'hF, w, acc0);
        end
        wait_resp(1, 6);
        req_b = 1'b1; wr = 1'b0; n = 0;
        for (int c = 0; c < 16 && n < 6; c++) begin
            addr = 32'h200 + 32'(4 * n);
            #1;
            okh[c] = ok_b; dokh[c] = dok_b; sampled = ok_b;
            @(posedge clk);
            if (sampled) n++;
            @(negedge clk);
        end
        req_b = 1'b0;
        check("full_accepts", 32'(n), 32'd6);
        for (int c = 0; c < 4; c++) check($sformatf("full_ok_%0d", c), 32'(okh[c]), 32'd1);
        check("full_ok_4", 32'(okh[4]), 32'd0);
        check("full_ok_5", 32'(okh[5]), 32'd0);
        check("full_dok_5", 32'(dokh[5]), 32'd0);
        check("full_ok_6", 32'(okh[6]), 32'd1);
        check("full_dok_6", 32'(dokh[6]), 32'd1);
        wait_resp(1, 12);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("full_rdata_%0d", i), resp_b[6 + i], 32'hB0000000 + 32'(i));
        end

        // Reset with three reads outstanding on the deep instance.
        for (int i = 0; i < 3; i++) issue(1, 1'b0, 32'h200, 32'h0, 4'h0, w, acc0);
        resetn = 1'b0;
        #1;
        check("midrst_data_ok", 32'(dok_b), 32'd0);
        check("midrst_rdata", rd_b, 32'h0);
        @(negedge clk); resetn = 1'b1;
        #1;
        check("midrst_count", 32'(u_dut_deep.count_q), 32'd0);
        repeat (12) @(negedge clk);
        check("midrst_no_resp", 32'(resp_b.size()), 32'd12);
        issue(1, 1'b0, 32'h204, 32'h0, 4'h0, w, acc0);
        wait_resp(1, 13);
        check("midrst_persist_b", resp_b[12], 32'hB0000001);
        issue(0, 1'b0, 32'h100, 32'h0, 4'h0, w, acc0);
        wait_resp(0, 10);
        check("midrst_persist_a", resp_a[9], 32'h11BB33DD);

        // Streaming alternating writes and reads.
        base = resp_a.size();
        for (int k = 0; k < 8; k++) begin
            issue(0, 1'b1, 32'h300 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 4'hF, w, acc0);
            check($sformatf("stream_wr_wait_%0d", k), 32'(w), 32'd0);
            issue(0, 1'b0, 32'h300 + 32'(4 * k), 32'h0, 4'h0, w, acc0);
            check($sformatf("stream_rd_wait_%0d", k), 32'(w), 32'd0);
        end
        wait_resp(0, base + 16);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("stream_wr_%0d", k), resp_a[base + 2 * k], 32'h0);
            check($sformatf("stream_rd_%0d", k), resp_a[base + 2 * k + 1],
                  32'hC0DE0000 + 32'(k));
        end
        check("stream_b2b", 32'(rcyc_a[base + 15] - rcyc_a[base]), 32'd15);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
